seg7_scan_ctrl: RTL

//   Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one seg_dec.

---
 rtl/seg7_scan_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg7_scan_ctrl : multiplexed 7-seg scanner, blanking gap between digits
// Rev 1.0
// ============================================================================
module seg7_scan_ctrl #(
  parameter int NUM_DIG = 4,
  parameter int DWELL   = 1000,
  parameter int BLANK   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   iEn,
  input  logic                   iLoad,
  input  logic [4*NUM_DIG-1:0]   iData,
  output logic [3:0]             oHex,
  output logic [NUM_DIG-1:0]     oDigitSel,
  output logic                   oBlank,
  output logic                   oFrame
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DIG);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);

  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   wrap;

  logic [4*NUM_DIG-1:0]   active_q, active_d;
  logic [4*NUM_DIG-1:0]   shadow_q, shadow_d;
  logic                   pending_q, pending_d;

  logic [3:0]             hex_q, hex_d;
  logic [NUM_DIG-1:0]     sel_q, sel_d;
  logic                   blank_q, blank_d;
  logic                   frame_q, frame_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (iEn) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (!iEn) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW: begin
        if (!iEn) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Active data only changes while idle or on the frame-boundary cycle
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (iLoad) begin
      shadow_d  = iData;
      pending_d = 1'b1;
    end
    if ((state_q == S_IDLE) || frame_q) begin
      if (iLoad)          active_d = iData;
      else if (pending_q) active_d = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Output logic: computed from next state so registered outputs track state_q
  always_comb begin
    frame_d = wrap;
    blank_d = (state_d != S_SHOW);
    sel_d   = '1;
    if (state_d == S_SHOW) sel_d[idx_d] = 1'b0;
    hex_d   = (state_d == S_IDLE) ? 4'h0 : active_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      hex_q     <= 4'h0;
      sel_q     <= '1;
      blank_q   <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      hex_q     <= hex_d;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      frame_q   <= frame_d;
    end
  end

  assign oHex      = hex_q;
  assign oDigitSel = sel_q;
  assign oBlank    = blank_q;
  assign oFrame    = frame_q;

endmodule
`default_nettype wire
